// File: rtl/mod_arith_pkg.sv
// Shared definitions for the limb-serial modular arithmetic blocks:
// FSM encoding, counter sizing and the operand/limb geometry check.
package mod_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach the value n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic bit limbs_ok(input int nbits, input int limb);
    return (limb > 0) && (nbits >= limb) && ((nbits % limb) == 0);
  endfunction

endpackage

// File: rtl/mod_add_limb.sv
// One limb of the serial modular adder: add with carry, then subtract the
// modulus limb with borrow. Purely combinational.
module mod_add_limb #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] a_i,
  input  logic [LIMB-1:0] b_i,
  input  logic [LIMB-1:0] q_i,
  input  logic            cin,
  input  logic            bin,
  output logic [LIMB-1:0] s_i,
  output logic [LIMB-1:0] d_i,
  output logic            cout,
  output logic            bout
);

  logic [LIMB:0] sum_w;
  logic [LIMB:0] dif_w;

  assign sum_w = {1'b0, a_i} + {1'b0, b_i} + {{LIMB{1'b0}}, cin};
  // The top bit of the LIMB+1-bit difference is set exactly when it went negative.
  assign dif_w = {1'b0, sum_w[LIMB-1:0]} - {1'b0, q_i} - {{LIMB{1'b0}}, bin};

  assign s_i  = sum_w[LIMB-1:0];
  assign cout = sum_w[LIMB];
  assign d_i  = dif_w[LIMB-1:0];
  assign bout = dif_w[LIMB];

endmodule

// File: rtl/mod_add_serial.sv
// Limb-serial modular adder y = (a + b) mod q, LSB limb first, with
// valid/ready handshakes on input and output.
module mod_add_serial
  import mod_arith_pkg::*;
#(
  parameter int NBITS = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] y
);

  localparam int NLIMBS = NBITS / LIMB;
  localparam int CW     = cnt_width(NLIMBS);

  generate
    if (!limbs_ok(NBITS, LIMB)) begin : g_bad_geometry
      $error("mod_add_serial: NBITS must be a nonzero multiple of LIMB");
    end
  endgenerate

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] a_sr, b_sr, q_sr;
  logic [NBITS-1:0] sum_r, diff_r;
  logic             carry, borrow;

  logic [LIMB-1:0]       s_i, d_i;
  logic                  cout, bout;
  logic [NBITS+LIMB-1:0] sum_cat, diff_cat;

  mod_add_limb #(.LIMB(LIMB)) u_limb (
    .a_i  (a_sr[LIMB-1:0]),
    .b_i  (b_sr[LIMB-1:0]),
    .q_i  (q_sr[LIMB-1:0]),
    .cin  (carry),
    .bin  (borrow),
    .s_i  (s_i),
    .d_i  (d_i),
    .cout (cout),
    .bout (bout)
  );

  // New limbs enter at the top so limb 0 ends up in the LSBs after NLIMBS shifts.
  assign sum_cat  = {s_i, sum_r};
  assign diff_cat = {d_i, diff_r};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      // NOTE: the wide operand/result shift registers are reset as well, so an
      // aborted operation leaves no residue visible on y or in later runs.
      a_sr      <= '0;
      b_sr      <= '0;
      q_sr      <= '0;
      sum_r     <= '0;
      diff_r    <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            q_sr     <= q;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (cnt == CW'(NLIMBS)) begin
            // (a+b) >= q when the top limb carried out or the subtraction did not borrow.
            y         <= (carry | ~borrow) ? diff_r : sum_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            a_sr   <= a_sr >> LIMB;
            b_sr   <= b_sr >> LIMB;
            q_sr   <= q_sr >> LIMB;
            sum_r  <= sum_cat[NBITS+LIMB-1:LIMB];
            diff_r <= diff_cat[NBITS+LIMB-1:LIMB];
            carry  <= cout;
            borrow <= bout;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
